// File: rtl/branch_pkg.sv
// branch_pkg: shared compare opcodes, funct3/kind encodings, FSM states and funct3 decode.
package branch_pkg;
  localparam logic [5:0] CMP_EQ  = 6'b000001;
  localparam logic [5:0] CMP_NE  = 6'b000010;
  localparam logic [5:0] CMP_LT  = 6'b000100;
  localparam logic [5:0] CMP_LTU = 6'b001000;
  localparam logic [5:0] CMP_GE  = 6'b010000;
  localparam logic [5:0] CMP_GEU = 6'b100000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [1:0] KIND_BR   = 2'b00;
  localparam logic [1:0] KIND_JAL  = 2'b01;
  localparam logic [1:0] KIND_JALR = 2'b10;
  localparam logic [1:0] KIND_RSV  = 2'b11;
  typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT} state_t;
  function automatic logic [5:0] decode_f3(input logic [2:0] f3);
    return f3 == F3_BEQ  ? CMP_EQ  :
           f3 == F3_BNE  ? CMP_NE  :
           f3 == F3_BLT  ? CMP_LT  :
           f3 == F3_BLTU ? CMP_LTU :
           f3 == F3_BGE  ? CMP_GE  :
           f3 == F3_BGEU ? CMP_GEU : 6'b0;
  endfunction
endpackage

// File: rtl/branch_unit_if.sv
// branch_unit_if: issue, fetch-redirect and result signals; BRANCH_PREDICT_EN adds prediction in/out.
interface branch_unit_if #(parameter int DW = 32);
  logic valid_i, ready_o, flush_i, redirect_valid_o, redirect_ready_i;
  logic done_o, taken_o, illegal_o, misalign_o;
  logic [1:0] kind_i;
  logic [2:0] funct3_i;
  logic [DW-1:0] pc_i, imm_i, rs1_i, rs2_i, redirect_pc_o, link_o;
`ifdef BRANCH_PREDICT_EN
  logic pred_taken_i, mispredict_o;
  modport slave (
    input valid_i, kind_i, funct3_i, pc_i, imm_i, rs1_i, rs2_i, flush_i, redirect_ready_i, pred_taken_i,
    output ready_o, redirect_valid_o, redirect_pc_o, done_o, taken_o, link_o, illegal_o, misalign_o, mispredict_o
  );
  modport master (
    output valid_i, kind_i, funct3_i, pc_i, imm_i, rs1_i, rs2_i, flush_i, redirect_ready_i, pred_taken_i,
    input ready_o, redirect_valid_o, redirect_pc_o, done_o, taken_o, link_o, illegal_o, misalign_o, mispredict_o
  );
`else
  modport slave (
    input valid_i, kind_i, funct3_i, pc_i, imm_i, rs1_i, rs2_i, flush_i, redirect_ready_i,
    output ready_o, redirect_valid_o, redirect_pc_o, done_o, taken_o, link_o, illegal_o, misalign_o
  );
  modport master (
    output valid_i, kind_i, funct3_i, pc_i, imm_i, rs1_i, rs2_i, flush_i, redirect_ready_i,
    input ready_o, redirect_valid_o, redirect_pc_o, done_o, taken_o, link_o, illegal_o, misalign_o
  );
`endif
endinterface

// File: rtl/comparator.sv
// comparator: evaluates one one-hot compare opcode on two operands; opcode 0 yields 0.
module comparator
  import branch_pkg::*;
#(parameter int DW = 32) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [5:0]    op,
  output logic          res
);
  always_comb
    res = op == CMP_EQ  ? a == b :
          op == CMP_NE  ? a != b :
          op == CMP_LT  ? $signed(a) < $signed(b) :
          op == CMP_LTU ? a < b :
          op == CMP_GE  ? $signed(a) >= $signed(b) :
          op == CMP_GEU ? a >= b : 1'b0;
endmodule

// File: rtl/branch_unit.sv
// branch_unit: RV32 branch/JAL/JALR resolve with handshaked fetch redirect.
// Optional BRANCH_PREDICT_EN: redirect only on mispredict, to target or pc+4.
module branch_unit
  import branch_pkg::*;
#(parameter int DW = 32) (
  input logic clk_i,
  input logic rst_i,
  branch_unit_if.slave bus
);
  state_t state, state_n;
  logic ready_q, done_q, taken_q, illegal_q, misalign_q;
  logic [1:0] kind_q;
  logic [2:0] f3_q;
  logic [5:0] op;
  logic [DW-1:0] pc_q, imm_q, rs1_q, rs2_q, link_q, rpc_q;
  logic accept, cmp, taken, illegal, misalign, need;
  logic [DW-1:0] target, link, rpc;
`ifdef BRANCH_PREDICT_EN
  logic pred_q, mispred_q, mispred;
`endif
  comparator #(.DW(DW)) u_cmp (.a(rs1_q), .b(rs2_q), .op(op), .res(cmp));
  always_comb begin
    op = decode_f3(f3_q);
    accept = state == IDLE && ready_q && bus.valid_i && !bus.flush_i;
    target = kind_q == KIND_JALR ? (rs1_q + imm_q) & ~DW'(1) : pc_q + imm_q;
    link = pc_q + DW'(4);
    illegal = kind_q == KIND_RSV || (kind_q == KIND_BR && op == 6'b0);
    taken = kind_q == KIND_BR ? cmp : !illegal;
    misalign = taken && target[1];
`ifdef BRANCH_PREDICT_EN
    mispred = taken != pred_q;
    need = mispred && !misalign;
    rpc = taken ? target : link;
`else
    need = taken && !misalign;
    rpc = target;
`endif
    state_n = bus.flush_i      ? IDLE :
              state == IDLE    ? (accept ? RESOLVE : IDLE) :
              state == RESOLVE ? (need ? REDIRECT : IDLE) :
              bus.redirect_ready_i ? IDLE : REDIRECT;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      ready_q <= 1'b0;
      done_q <= 1'b0;
      taken_q <= 1'b0;
      illegal_q <= 1'b0;
      misalign_q <= 1'b0;
      kind_q <= '0;
      f3_q <= '0;
      pc_q <= '0;
      imm_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      link_q <= '0;
      rpc_q <= '0;
`ifdef BRANCH_PREDICT_EN
      pred_q <= 1'b0;
      mispred_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ready_q <= state_n == IDLE;
      done_q <= state == RESOLVE && !bus.flush_i && !need;
      if (accept) begin
        kind_q <= bus.kind_i;
        f3_q <= bus.funct3_i;
        pc_q <= bus.pc_i;
        imm_q <= bus.imm_i;
        rs1_q <= bus.rs1_i;
        rs2_q <= bus.rs2_i;
`ifdef BRANCH_PREDICT_EN
        pred_q <= bus.pred_taken_i;
`endif
      end
      if (state == RESOLVE) begin
        taken_q <= taken;
        illegal_q <= illegal;
        misalign_q <= misalign;
        link_q <= link;
        rpc_q <= rpc;
`ifdef BRANCH_PREDICT_EN
        mispred_q <= mispred;
`endif
      end
    end
  end
  assign bus.ready_o = ready_q;
  assign bus.redirect_valid_o = state == REDIRECT;
  assign bus.redirect_pc_o = rpc_q;
  // a redirected instruction completes in the very cycle fetch takes the redirect
  assign bus.done_o = done_q || (state == REDIRECT && bus.redirect_ready_i && !bus.flush_i);
  assign bus.taken_o = taken_q;
  assign bus.link_o = link_q;
  assign bus.illegal_o = illegal_q;
  assign bus.misalign_o = misalign_q;
`ifdef BRANCH_PREDICT_EN
  assign bus.mispredict_o = mispred_q;
`endif
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: randomized scoreboard bench for branch_unit with a behavioural reference model.
module tb_branch_unit;
  typedef struct {
    int acc;
    bit redir, seen, exact, taken, illegal, misalign, mispred;
    logic [31:0] rpc, link;
  } exp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, checks = 0, errors = 0;
  bit rdy_fix = 0, rdy_rnd = 0, rdy_random = 0, ign_redir = 0;
  exp_t sb[$];
  branch_unit_if #(.DW(32)) bus();
  branch_unit #(.DW(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rdy_rnd = $urandom_range(0, 2) != 0;
  end
  assign bus.redirect_ready_i = rdy_random ? rdy_rnd : rdy_fix;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask
  function automatic exp_t model(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b, input bit pr);
    exp_t e;
    logic [31:0] tgt;
    e = '{default: 0};
    e.link = pc + 4;
    tgt = (k == 2) ? ((a + imm) & 32'hFFFF_FFFE) : pc + imm;
    if (k == 0)
      case (f3)
        0: e.taken = a == b;
        1: e.taken = a != b;
        4: e.taken = $signed(a) < $signed(b);
        5: e.taken = $signed(a) >= $signed(b);
        6: e.taken = a < b;
        7: e.taken = a >= b;
        default: e.illegal = 1;
      endcase
    else if (k == 3) e.illegal = 1;
    else e.taken = 1;
    e.misalign = e.taken && tgt[1];
`ifdef BRANCH_PREDICT_EN
    e.mispred = e.taken != pr;
    e.redir = e.mispred && !e.misalign;
    e.rpc = e.taken ? tgt : e.link;
`else
    e.mispred = pr && 1'b0;
    e.redir = e.taken && !e.misalign;
    e.rpc = tgt;
`endif
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.redirect_valid_o && !ign_redir) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_redirect actual=1 required=0");
        end else begin
          chk("redirect_wanted", 1, sb[0].redir);
          chk("redirect_pc", bus.redirect_pc_o, sb[0].rpc);
          if (!sb[0].seen) begin
            chk("redirect_cycle", cyc, sb[0].acc + 2);
            sb[0].seen = 1;
          end
        end
      end
      if (bus.done_o) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = sb.pop_front();
          chk("taken", bus.taken_o, e.taken);
          chk("link", bus.link_o, e.link);
          chk("illegal", bus.illegal_o, e.illegal);
          chk("misalign", bus.misalign_o, e.misalign);
          chk("redirected", bus.redirect_valid_o, e.redir);
`ifdef BRANCH_PREDICT_EN
          chk("mispredict", bus.mispredict_o, e.mispred);
`endif
          if (!e.redir || e.exact) chk("done_cycle", cyc, e.acc + 2);
        end
      end
    end
  end
  task automatic issue(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b, input bit pr, input bit push);
    exp_t e;
    int t = 0;
    @(posedge clk); #1;
    while (!bus.ready_o && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.ready_o) begin
      chk("issue_timeout", 0, 1);
      return;
    end
    bus.kind_i = k; bus.funct3_i = f3; bus.pc_i = pc; bus.imm_i = imm; bus.rs1_i = a; bus.rs2_i = b;
`ifdef BRANCH_PREDICT_EN
    bus.pred_taken_i = pr;
`endif
    bus.valid_i = 1;
    if (push) begin
      e = model(k, f3, pc, imm, a, b, pr);
      e.acc = cyc;
      e.exact = !rdy_random && rdy_fix;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.valid_i = 0;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 0);
  endtask
  task automatic chk_zero(input string name);
    chk(name, {bus.ready_o, bus.done_o, bus.redirect_valid_o, bus.taken_o, bus.illegal_o, bus.misalign_o}, 0);
    chk({name, "_link"}, bus.link_o, 0);
    chk({name, "_pc"}, bus.redirect_pc_o, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] k;
    logic [31:0] a, b;
    bus.valid_i = 0; bus.flush_i = 0; bus.kind_i = 0; bus.funct3_i = 0;
    bus.pc_i = 0; bus.imm_i = 0; bus.rs1_i = 0; bus.rs2_i = 0;
`ifdef BRANCH_PREDICT_EN
    bus.pred_taken_i = 0;
`endif
    repeat (2) @(negedge clk);
    chk_zero("reset_outs");
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("ready_at_release", bus.ready_o, 0);
    @(negedge clk);
    chk("ready_after_release", bus.ready_o, 1);
    rdy_fix = 1;
    issue(0, 3'b000, 32'h100, 32'h20, 5, 5, 0, 1);
    issue(0, 3'b100, 32'h100, 32'h8, 32'hFFFF_FFFF, 1, 0, 1);
    issue(0, 3'b110, 32'h100, 32'h8, 32'hFFFF_FFFF, 1, 0, 1);
    issue(2, 3'b000, 32'h200, 32'h2, 32'h1001, 0, 0, 1);
    issue(0, 3'b000, 32'hFFFF_FFFC, 32'h8, 3, 3, 0, 1);
    issue(0, 3'b010, 32'h300, 32'h10, 1, 1, 0, 1);
    issue(1, 3'b010, 32'h800, 32'h100, 0, 0, 0, 1);
    issue(3, 3'b000, 32'h900, 32'h10, 0, 0, 0, 1);
    drain();
    rdy_fix = 0;
    issue(0, 3'b001, 32'h400, 32'h40, 1, 2, 0, 1);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready", bus.ready_o, 0);
      chk("stall_valid", bus.redirect_valid_o, 1);
      chk("stall_pc", bus.redirect_pc_o, 32'h440);
      chk("stall_done", bus.done_o, 0);
    end
    @(posedge clk); #1;
    rdy_fix = 1;
    drain();
    rdy_fix = 0;
    ign_redir = 1;
    issue(0, 3'b000, 32'h500, 32'h10, 7, 7, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("flush_pre_valid", bus.redirect_valid_o, 1);
    @(posedge clk); #1;
    bus.flush_i = 1; rdy_fix = 1;
    @(negedge clk);
    chk("flush_done", bus.done_o, 0);
    @(posedge clk); #1;
    bus.flush_i = 0; rdy_fix = 0;
    @(negedge clk);
    chk("flush_ready", bus.ready_o, 1);
    chk("flush_valid", bus.redirect_valid_o, 0);
    ign_redir = 0;
    @(posedge clk); #1;
    bus.kind_i = 1; bus.pc_i = 32'hA00; bus.imm_i = 32'h10;
    bus.valid_i = 1; bus.flush_i = 1;
    @(posedge clk); #1;
    bus.valid_i = 0; bus.flush_i = 0;
    @(negedge clk);
    chk("flush_idle_ready", bus.ready_o, 1);
    repeat (3) @(negedge clk);
    rdy_fix = 1;
    issue(0, 3'b000, 32'h600, 32'h10, 1, 1, 0, 0);
    #2;
    rst = 1;
    #1;
    chk_zero("async_reset_outs");
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("ready_at_release2", bus.ready_o, 0);
    @(negedge clk);
    chk("ready_after_release2", bus.ready_o, 1);
`ifdef BRANCH_PREDICT_EN
    issue(0, 3'b001, 32'h700, 32'h20, 1, 2, 1, 1);
    issue(0, 3'b001, 32'h700, 32'h20, 3, 3, 1, 1);
    drain();
`endif
    rdy_random = 1;
    repeat (150) begin
      k = ($urandom_range(0, 7) < 5) ? 2'd0 : 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      issue(k, 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 1) ? ($urandom & 32'hFFE) : $urandom, a, b, 1'($urandom_range(0, 1)), 1);
    end
    drain();
    rdy_random = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
